// File: rtl/gp_carry_pkg.sv
// -----------------------------------------------------------------------------
// gp_carry_pkg
// Shared types and helpers for the pipelined G/P carry-lookahead adder.
//   gp_t        : packed generate/propagate pair
//   gp_levels() : number of Kogge-Stone levels for a given operand width
//   gp_combine(): prefix operator, (Gh,Ph) o (Gl,Pl)
// -----------------------------------------------------------------------------
package gp_carry_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix-tree depth is always derived from the width, never set by hand.
    function automatic int gp_levels(input int width);
        return $clog2(width);
    endfunction

    // Combine a higher-order group with the adjacent lower-order group.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

endpackage : gp_carry_pkg

// File: rtl/gp_carry_pipe_prefix_tree.sv
// -----------------------------------------------------------------------------
// gp_prefix_tree
// Purely combinational Kogge-Stone prefix tree.
// Ports:
//   g, p   [WIDTH-1:0] : per-bit generate / propagate
//   c0                 : carry into bit 0
//   carry  [WIDTH:0]   : carry into each bit; carry[WIDTH] is the carry-out
//   grp_g, grp_p       : group generate / propagate over all bits
// -----------------------------------------------------------------------------
module gp_prefix_tree
    import gp_carry_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             c0,
    output logic [WIDTH:0]   carry,
    output logic             grp_g,
    output logic             grp_p
);

    localparam int LEVELS = gp_levels(WIDTH);

    // lvl[k][i] holds the group (G,P) spanning bits [i : max(0, i-2^k+1)].
    gp_t [LEVELS:0][WIDTH-1:0] lvl;

    always_comb begin
        // NOTE: every output gets a default before the loops, so no path can
        // leave a variable unassigned and infer a latch.
        lvl   = '0;
        carry = '0;
        grp_g = 1'b0;
        grp_p = 1'b0;

        for (int i = 0; i < WIDTH; i++) begin
            lvl[0][i].g = g[i];
            lvl[0][i].p = p[i];
        end

        for (int k = 1; k <= LEVELS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << (k - 1)))
                    lvl[k][i] = gp_combine(lvl[k-1][i], lvl[k-1][i - (1 << (k - 1))]);
                else
                    lvl[k][i] = lvl[k-1][i];
            end
        end

        // After the last level every node spans down to bit 0, so the carry
        // into bit i+1 needs only one AND-OR with the external carry-in.
        carry[0] = c0;
        for (int i = 0; i < WIDTH; i++)
            carry[i+1] = lvl[LEVELS][i].g | (lvl[LEVELS][i].p & c0);

        grp_g = lvl[LEVELS][WIDTH-1].g;
        grp_p = lvl[LEVELS][WIDTH-1].p;
    end

endmodule : gp_prefix_tree

// File: rtl/gp_carry_pipe.sv
// -----------------------------------------------------------------------------
// gp_carry_pipe
// Two-stage pipelined G/P carry-lookahead adder/subtractor with an elastic
// valid/ready interface on both sides.
//   S1 registers per-bit g/p and the carry-in; S2 registers the result.
// Ports:
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready combinational from out_ready)
//   a, b [WIDTH-1:0]      : operands
//   cin                   : carry-in, ignored when sub=1
//   sub                   : 0 -> a+b+cin, 1 -> a-b
//   out_valid / out_ready : result handshake
//   sum [WIDTH-1:0]       : result (modulo 2^WIDTH)
//   cout                  : carry-out (subtract: 1 = no borrow)
//   grp_g, grp_p          : group generate / propagate over all bits
//   ovf                   : signed overflow, only when GP_CARRY_OVF_EN is defined
// Build option: define GP_CARRY_OVF_EN to add the registered ovf output.
// -----------------------------------------------------------------------------
module gp_carry_pipe
    import gp_carry_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             grp_g,
    output logic             grp_p
`ifdef GP_CARRY_OVF_EN
    ,
    output logic             ovf
`endif
);

    // ---------------------------------------------------------------- control
    logic adv1;
    logic adv2;
    logic s1_valid;
    logic s2_valid;

    // A stage may load when it is empty or when its contents move on this edge.
    assign adv2      = ~s2_valid | out_ready;
    assign adv1      = ~s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // ---------------------------------------------------------------- stage 1
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_c0;

    // Subtraction is a + ~b + 1.
    assign b_eff = sub ? ~b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset along with the valid flags, so the
        // outputs read 0 rather than stale operands after reset.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_c0    <= 1'b0;
        end else if (adv1) begin
            // NOTE: non-blocking assignments, so each register samples the
            // pre-edge values whatever the statement order.
            s1_valid <= in_valid;
            s1_g     <= a & b_eff;
            s1_p     <= a ^ b_eff;
            s1_c0    <= sub | cin;
        end
    end

    // ------------------------------------------------------------ prefix tree
    logic [WIDTH:0] carry;
    logic           tree_g;
    logic           tree_p;

    gp_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .g     (s1_g),
        .p     (s1_p),
        .c0    (s1_c0),
        .carry (carry),
        .grp_g (tree_g),
        .grp_p (tree_p)
    );

    // ---------------------------------------------------------------- stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            grp_g    <= 1'b0;
            grp_p    <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            sum      <= s1_p ^ carry[WIDTH-1:0];
            cout     <= carry[WIDTH];
            grp_g    <= tree_g;
            grp_p    <= tree_p;
        end
    end

`ifdef GP_CARRY_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (adv2)
            ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
`endif

endmodule : gp_carry_pipe

// File: tb/tb_gp_carry_pipe.sv
// -----------------------------------------------------------------------------
// tb_gp_carry_pipe
// Self-checking bench for gp_carry_pipe (WIDTH=16). Expected results come from
// a plain-arithmetic model and an in-order scoreboard queue.
// -----------------------------------------------------------------------------
module tb_gp_carry_pipe;

    localparam int W = 16;

    typedef logic [W+3:0] res_t;   // {ovf, grp_g, grp_p, cout, sum}

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         grp_g;
    logic         grp_p;
`ifdef GP_CARRY_OVF_EN
    logic         ovf;
`endif

    int   tests    = 0;
    int   fails    = 0;
    int   accepted = 0;
    res_t sb[$];

    gp_carry_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .grp_g     (grp_g),
        .grp_p     (grp_p)
`ifdef GP_CARRY_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: straight integer arithmetic on the effective operands.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   full;
        logic [W:0]   nocin;
        logic         g, p, o;
        be    = msub ? ~mb : mb;
        c0    = msub ? 1'b1 : mcin;
        full  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c0};
        nocin = {1'b0, ma} + {1'b0, be};
        g     = nocin[W];                 // carry-out with no carry-in
        p     = &(ma ^ be);               // carry-in would ripple all the way
`ifdef GP_CARRY_OVF_EN
        o     = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
`else
        o     = 1'b0;
`endif
        return {o, g, p, full[W], full[W-1:0]};
    endfunction

    function automatic res_t observed();
        logic o;
`ifdef GP_CARRY_OVF_EN
        o = ovf;
`else
        o = 1'b0;
`endif
        return {o, grp_g, grp_p, cout, sum};
    endfunction

    // One clock: observe handshakes at the falling edge, advance, settle.
    task automatic cycle();
        res_t held;
        logic hold_chk;
        @(negedge clk);
        hold_chk = out_valid && !out_ready;
        held     = observed();
        if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            accepted++;
        end
        if (out_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0)
                check("result", observed(), sb.pop_front());
        end
        @(posedge clk);
        #1;
        if (hold_chk) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", observed(), held);
        end
    endtask

    task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tsub, input logic [W-1:0] es,
                            input logic ec, input logic eg, input logic ep, input logic eo);
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();                       // accepting edge
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        cycle();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_g"}, grp_g, eg);
        check({tag, "_p"}, grp_p, ep);
`ifdef GP_CARRY_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`else
        if (eo) ;
`endif
        cycle();
        check({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        int target;
        int cyc;

        // ------------------------------------------------------------ reset
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_grp", {grp_g, grp_p}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // --------------------------------------------------------- directed
        directed("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("add_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef GP_CARRY_OVF_EN
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
`endif

        // ---------------------------------------------------- stall burst
        out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        a = 16'd1; b = 16'd1;
        cycle();
        a = 16'd2; b = 16'd2;
        cycle();
        check("burst_first_valid", out_valid, 1'b1);
        check("burst_first_sum", sum, 16'h0002);
        a = 16'd3; b = 16'd3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("burst_hold_sum", sum, 16'h0002);
            check("burst_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("burst_r2", sum, 16'h0004);
        cycle();
        check("burst_r3", sum, 16'h0006);
        cycle();
        check("burst_empty", out_valid, 1'b0);
        check("burst_sb_empty", sb.size(), 0);

        // ------------------------------------------------ full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            cycle();
            if (i >= 1)
                check("throughput", out_valid, 1'b1);
        end

        // ------------------------------------------------- random stream
        target = accepted + 10000;
        cyc    = 0;
        while (accepted < target && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            cycle();
            cyc++;
        end
        check("random_complete", accepted >= target, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("drain_sb_empty", sb.size(), 0);

        // -------------------------------------------- reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        a = 16'd10; b = 16'd20;
        cycle();
        a = 16'd30; b = 16'd40;
        cycle();
        in_valid = 1'b0;
        check("mid_full", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_sum", sum, 16'h0000);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("no_stale", out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_gp_carry_pipe
